pic_priority_arbiter: RTL and testbench
=======================================

Name: pic_priority_arbiter

Overview:
- Clocked priority resolver and acknowledge sequencer for the 8-input interrupt controller.
- Latches requests into IRR and applies the IMR mask.
- Picks the winner by fully nested, rotating priority against ISR, and drives INT.
- Walks the two-pulse INTA handshake to set ISR and emit the vector {icw2 base, level}; services EOI commands from the OCW decode path.

Parameters:
RESET_LOWEST_PRIO, 7, level holding lowest priority after reset (IR0 highest by default).
ACK_TIMEOUT, 0, cycles INT may wait for first INTA before abandoning the request; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
irq_in  input  8  synchronous interrupt request lines IR7..IR0.
ltim  input  1  1 = level-triggered, 0 = edge-triggered (ICW1 bit 3).
imr  input  8  interrupt mask, 1 = masked (OCW1).
vec_base  input  5  vector bits T7..T3 (ICW2[7:3]).
inta_strobe  input  1  one-cycle pulse per INTA falling edge.
eoi_strobe  input  1  one-cycle EOI command pulse.
eoi_specific  input  1  1 = specific EOI using eoi_level.
eoi_rotate  input  1  1 = rotate on this EOI.
eoi_level  input  3  level for specific EOI.
int_out  output  1  interrupt request to CPU.
vector  output  8  vector byte.
vector_valid  output  1  vector on bus this cycle.
isr  output  8  in-service register.
irr  output  8  interrupt request register.

Behaviour:
- Reset: irr=0, isr=0, int_out=0, vector=0, vector_valid=0, lowest_prio=RESET_LOWEST_PRIO, state=IDLE, timeout counter=0.
- IRR, edge mode: bit sets on a 0->1 transition of irq_in against the registered previous value. Bit stays set until cleared at ACK1 or by timeout.
- IRR, level mode: bit = irq_in each cycle, except the bit just acknowledged is cleared at ACK1.
- Priority: highest = lowest_prio+1 mod 8, descending cyclically. Candidate = highest-priority bit of (irr & ~imr).
- Nesting: candidate wins only if strictly higher priority than the highest ISR bit, or ISR=0.
- IDLE: a winner exists -> REQ, with int_out=1 registered one cycle after the IRR bit is visible.
- REQ: int_out held high.
  - Winner disappears (mask or level drop) before INTA -> int_out=0, back to IDLE.
  - If ACK_TIMEOUT>0 and the counter reaches ACK_TIMEOUT -> clear that IRR bit, int_out=0, IDLE.
  - inta_strobe -> ACK1.
- On entering ACK1: winner re-evaluated this cycle; isr[winner] set, irr[winner] cleared, int_out=0.
- Spurious: no winner at ACK1 -> level latched as 7, ISR unchanged.
- ACK1 + inta_strobe -> vector={vec_base,level}, vector_valid=1 for exactly one cycle, then IDLE (or REQ next cycle if another winner exists).
- EOI non-specific: clear the highest-priority set ISR bit; no-op if ISR=0.
- EOI specific: clear isr[eoi_level].
- eoi_rotate=1: lowest_prio becomes the cleared level.
- EOI coincident with ACK1: apply the ISR set first, then the EOI clear.
- EOI during REQ: priority recomputed next cycle.
- inta_strobe in IDLE is ignored. vector stays at its last value; only vector_valid qualifies it.
- Reset mid-handshake: immediate return to reset values.

Optional Feature:
PIC_AEOI_EN defined:
- Adds input aeoi (ICW4 AEOI bit) and input aeoi_rotate.
- When aeoi=1, the ISR bit set at ACK1 is cleared in the cycle vector_valid=1. If aeoi_rotate=1, lowest_prio becomes that level.
Undefined:
- Ports absent; ISR cleared only by EOI commands.

Test Plan:
- Reset, edge mode, imr=0, pulse irq_in[3], vec_base=5'h08 -> int_out=1 two cycles later; two inta_strobe -> isr=8'h08, irr=0, vector=8'h43 with vector_valid one cycle.
- irq_in=8'h22 simultaneously, default priority -> IR1 served first (vector low bits 1); non-specific EOI -> IR5 then raises int_out.
- isr[2] set, raise IR4 -> int_out stays 0; raise IR0 -> int_out=1 (nesting); specific EOI level 2 clears only isr[2].
- Rotating EOI on level 4 -> lowest_prio=4; simultaneous IR3 and IR6 -> IR6 wins.
- Level mode, irq_in[7] dropped after int_out before INTA -> int_out falls, IDLE. If it drops between the two INTAs -> spurious vector {vec_base,3'd7}, isr unchanged.
- ACK_TIMEOUT=10, no INTA -> int_out deasserts after 10 cycles and the irr bit clears. With PIC_AEOI_EN and aeoi=1 -> isr=0 after the second INTA.

Source files
------------

// File: rtl/pic_priority_arbiter.sv
// -----------------------------------------------------------------------------
// pic_priority_arbiter
//
// Priority resolver and INTA sequencer for an 8-input interrupt controller.
// Requests are captured into IRR (edge- or level-triggered), masked by IMR and
// resolved with a rotating, fully nested priority scheme against ISR. The
// winner raises int_out. The two-pulse INTA handshake moves it into ISR and
// puts the vector {vec_base, level} on the bus. EOI commands clear ISR bits and
// can rotate priority.
//
// Optional feature (macro PIC_AEOI_EN): adds inputs aeoi and aeoi_rotate. With
// aeoi=1 the ISR bit is cleared automatically when the vector is issued.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   irq_in[7:0]       synchronous request lines IR7..IR0
//   ltim              1 = level-triggered, 0 = edge-triggered
//   imr[7:0]          interrupt mask, 1 = masked
//   vec_base[4:0]     vector bits T7..T3
//   inta_strobe       one-cycle pulse per INTA falling edge
//   eoi_strobe        one-cycle EOI command pulse
//   eoi_specific      1 = clear isr[eoi_level], 0 = clear highest ISR bit
//   eoi_rotate        1 = cleared level becomes lowest priority
//   eoi_level[2:0]    level for a specific EOI
//   aeoi, aeoi_rotate (PIC_AEOI_EN only) automatic EOI enable / rotate
//   int_out           interrupt request to CPU
//   vector[7:0]       vector byte, qualified by vector_valid
//   vector_valid      vector on bus this cycle
//   isr[7:0]          in-service register
//   irr[7:0]          interrupt request register
// -----------------------------------------------------------------------------
module pic_priority_arbiter #(
    parameter int RESET_LOWEST_PRIO = 7,
    parameter int ACK_TIMEOUT       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       ltim,
    input  logic [7:0] imr,
    input  logic [4:0] vec_base,
    input  logic       inta_strobe,
    input  logic       eoi_strobe,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
`ifdef PIC_AEOI_EN
    input  logic       aeoi,
    input  logic       aeoi_rotate,
`endif
    output logic       int_out,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic [7:0] isr,
    output logic [7:0] irr
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [2:0] RESET_LP = 3'(RESET_LOWEST_PRIO);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK1 = 2'd2
    } state_t;

    // Returns {found, level} of the highest-priority set bit. Levels are walked
    // from lowest to highest priority so the last hit is the winner.
    function automatic logic [3:0] pick_highest(input logic [7:0] bits, input logic [2:0] lowest);
        logic [3:0] found;
        logic [2:0] lvl;
        found = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            lvl   = lowest + 3'd1 + 3'(i);
            found = bits[lvl] ? {1'b1, lvl} : found;
        end
        return found;
    endfunction

    // Priority rank: 0 = highest priority, 7 = lowest.
    function automatic logic [2:0] prio_rank(input logic [2:0] lvl, input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] lvl);
        return 8'd1 << lvl;
    endfunction

    state_t           state_r;
    logic [7:0]       irq_prev_r;
    logic [7:0]       irr_r;
    logic [7:0]       isr_r;
    logic             int_r;
    logic [7:0]       vector_r;
    logic             vvalid_r;
    logic [2:0]       lowest_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ack_eval_r;   // first ACK1 cycle: winner still to be resolved
    logic [2:0]       ack_level_r;
    logic             ack_spur_r;

    logic             aeoi_s;
    logic             aeoi_rot_s;
    logic [3:0]       cand_s;
    logic [3:0]       isr_top_s;
    logic             winner_s;
    logic [2:0]       winner_lvl_s;
    logic             eval_s;
    logic [2:0]       cur_level_s;
    logic             cur_spur_s;
    logic             vec_take_s;
    logic             timeout_s;
    logic [7:0]       isr_set_s;
    logic [7:0]       irr_clr_s;
    logic [7:0]       aeoi_clr_s;
    logic [7:0]       isr_mid_s;
    logic [3:0]       eoi_pick_s;
    logic             eoi_hit_s;
    logic [2:0]       eoi_lvl_s;
    logic [7:0]       isr_next_s;
    logic [7:0]       irr_next_s;
    logic [2:0]       lowest_next_s;

`ifdef PIC_AEOI_EN
    assign aeoi_s     = aeoi;
    assign aeoi_rot_s = aeoi_rotate;
`else
    assign aeoi_s     = 1'b0;
    assign aeoi_rot_s = 1'b0;
`endif

    // Priority resolution, ISR/IRR next-state and priority rotation.
    always_comb begin
        cand_s       = pick_highest(irr_r & ~imr, lowest_r);
        isr_top_s    = pick_highest(isr_r, lowest_r);
        winner_lvl_s = cand_s[2:0];
        // Fully nested: only a strictly higher level may preempt in-service ones.
        winner_s     = cand_s[3] &&
                       (!isr_top_s[3] ||
                        (prio_rank(cand_s[2:0], lowest_r) < prio_rank(isr_top_s[2:0], lowest_r)));

        eval_s       = (state_r == ST_ACK1) && ack_eval_r;
        cur_level_s  = eval_s ? (winner_s ? winner_lvl_s : 3'd7) : ack_level_r;
        cur_spur_s   = eval_s ? !winner_s : ack_spur_r;
        vec_take_s   = (state_r == ST_ACK1) && inta_strobe;
        timeout_s    = (ACK_TIMEOUT > 0) && (state_r == ST_REQ) && !inta_strobe &&
                       winner_s && (cnt_r == CNT_LAST);

        isr_set_s    = (eval_s && winner_s) ? onehot(winner_lvl_s) : 8'd0;
        irr_clr_s    = isr_set_s | (timeout_s ? onehot(winner_lvl_s) : 8'd0);
        aeoi_clr_s   = (vec_take_s && aeoi_s && !cur_spur_s) ? onehot(cur_level_s) : 8'd0;

        // ACK1 set is applied before any coincident EOI clear.
        isr_mid_s    = (isr_r | isr_set_s) & ~aeoi_clr_s;
        eoi_pick_s   = pick_highest(isr_mid_s, lowest_r);
        if (eoi_strobe) begin
            if (eoi_specific) begin
                eoi_hit_s = 1'b1;
                eoi_lvl_s = eoi_level;
            end else begin
                eoi_hit_s = eoi_pick_s[3];
                eoi_lvl_s = eoi_pick_s[2:0];
            end
        end else begin
            eoi_hit_s = 1'b0;
            eoi_lvl_s = 3'd0;
        end
        isr_next_s   = isr_mid_s & ~(eoi_hit_s ? onehot(eoi_lvl_s) : 8'd0);

        if (eoi_hit_s && eoi_rotate) begin
            lowest_next_s = eoi_lvl_s;
        end else if ((aeoi_clr_s != 8'd0) && aeoi_rot_s) begin
            lowest_next_s = cur_level_s;
        end else begin
            lowest_next_s = lowest_r;
        end

        if (ltim) begin
            irr_next_s = irq_in & ~irr_clr_s;
        end else begin
            irr_next_s = (irr_r & ~irr_clr_s) | (irq_in & ~irq_prev_r);
        end
    end

    // Registers and the IDLE -> REQ -> ACK1 handshake sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            irq_prev_r  <= 8'd0;
            irr_r       <= 8'd0;
            isr_r       <= 8'd0;
            int_r       <= 1'b0;
            vector_r    <= 8'd0;
            vvalid_r    <= 1'b0;
            lowest_r    <= RESET_LP;
            cnt_r       <= '0;
            ack_eval_r  <= 1'b0;
            ack_level_r <= 3'd0;
            ack_spur_r  <= 1'b0;
        end else begin
            irq_prev_r <= irq_in;
            irr_r      <= irr_next_s;
            isr_r      <= isr_next_s;
            lowest_r   <= lowest_next_s;
            vvalid_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (winner_s) begin
                        state_r <= ST_REQ;
                        int_r   <= 1'b1;
                    end else begin
                        int_r   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // INTA takes precedence; a vanished winner then becomes spurious.
                    if (inta_strobe) begin
                        state_r    <= ST_ACK1;
                        int_r      <= 1'b0;
                        ack_eval_r <= 1'b1;
                        cnt_r      <= '0;
                    end else if (!winner_s || timeout_s) begin
                        state_r <= ST_IDLE;
                        int_r   <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_ACK1: begin
                    int_r       <= 1'b0;
                    ack_eval_r  <= 1'b0;
                    ack_level_r <= cur_level_s;
                    ack_spur_r  <= cur_spur_s;
                    if (inta_strobe) begin
                        vector_r <= {vec_base, cur_level_s};
                        vvalid_r <= 1'b1;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= ST_ACK1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    int_r   <= 1'b0;
                end
            endcase
        end
    end

    assign int_out      = int_r;
    assign vector       = vector_r;
    assign vector_valid = vvalid_r;
    assign isr          = isr_r;
    assign irr          = irr_r;

endmodule

// File: tb/tb_pic_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pic_priority_arbiter
//
// Directed bench for pic_priority_arbiter. Inputs change on the falling edge,
// outputs are sampled on the falling edge. A second instance with a 10-cycle
// acknowledge timeout exercises request abandonment.
// -----------------------------------------------------------------------------
module tb_pic_priority_arbiter;

    logic       clk          = 1'b0;
    logic       rst_n        = 1'b0;
    logic [7:0] irq_in       = 8'd0;
    logic [7:0] irq_to       = 8'd0;
    logic       ltim         = 1'b0;
    logic [7:0] imr          = 8'd0;
    logic [4:0] vec_base     = 5'h08;
    logic       inta_strobe  = 1'b0;
    logic       inta_to      = 1'b0;
    logic       eoi_strobe   = 1'b0;
    logic       eoi_specific = 1'b0;
    logic       eoi_rotate   = 1'b0;
    logic [2:0] eoi_level    = 3'd0;
    logic       aeoi         = 1'b0;
    logic       aeoi_rotate  = 1'b0;

    logic       int_out, vector_valid;
    logic [7:0] vector, isr, irr;
    logic       int_to, vvalid_to;
    logic [7:0] vector_to, isr_to, irr_to;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pic_priority_arbiter u_dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .ltim(ltim), .imr(imr),
        .vec_base(vec_base), .inta_strobe(inta_strobe), .eoi_strobe(eoi_strobe),
        .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
`ifdef PIC_AEOI_EN
        .aeoi(aeoi), .aeoi_rotate(aeoi_rotate),
`endif
        .int_out(int_out), .vector(vector), .vector_valid(vector_valid),
        .isr(isr), .irr(irr)
    );

    pic_priority_arbiter #(.ACK_TIMEOUT(10)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_to), .ltim(1'b0), .imr(8'd0),
        .vec_base(vec_base), .inta_strobe(inta_to), .eoi_strobe(eoi_strobe),
        .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
`ifdef PIC_AEOI_EN
        .aeoi(aeoi), .aeoi_rotate(aeoi_rotate),
`endif
        .int_out(int_to), .vector(vector_to), .vector_valid(vvalid_to),
        .isr(isr_to), .irr(irr_to)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_inta();
        inta_strobe = 1'b1;
        tick(1);
        inta_strobe = 1'b0;
    endtask

    task automatic pulse_eoi(input logic specific, input logic rotate, input logic [2:0] level);
        eoi_specific = specific;
        eoi_rotate   = rotate;
        eoi_level    = level;
        eoi_strobe   = 1'b1;
        tick(1);
        eoi_strobe   = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate   = 1'b0;
    endtask

    // Full handshake from REQ; returns in the cycle vector_valid is high.
    task automatic ack_cycle();
        pulse_inta();
        tick(1);
        pulse_inta();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL reset_irr: got %h want 00", irr); end
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL reset_isr: got %h want 00", isr); end
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", int_out); end
        n_cmp++; if (vector !== 8'h00) begin n_fail++; $display("FAIL reset_vector: got %h want 00", vector); end
        n_cmp++; if (vector_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid: got %b want 0", vector_valid); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_edge_basic();
        irq_in = 8'h08;
        tick(1);
        irq_in = 8'h00;
        n_cmp++; if (irr !== 8'h08) begin n_fail++; $display("FAIL edge_irr: got %h want 08", irr); end
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL edge_int_early: got %b want 0", int_out); end
        tick(1);
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL edge_int: got %b want 1", int_out); end
        pulse_inta();
        tick(1);
        n_cmp++; if (isr !== 8'h08) begin n_fail++; $display("FAIL edge_isr: got %h want 08", isr); end
        n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL edge_irr_clr: got %h want 00", irr); end
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL edge_int_ack: got %b want 0", int_out); end
        n_cmp++; if (vector_valid !== 1'b0) begin n_fail++; $display("FAIL edge_vvalid_early: got %b want 0", vector_valid); end
        pulse_inta();
        n_cmp++; if (vector !== 8'h43) begin n_fail++; $display("FAIL edge_vector: got %h want 43", vector); end
        n_cmp++; if (vector_valid !== 1'b1) begin n_fail++; $display("FAIL edge_vvalid: got %b want 1", vector_valid); end
        tick(1);
        n_cmp++; if (vector_valid !== 1'b0) begin n_fail++; $display("FAIL edge_vvalid_once: got %b want 0", vector_valid); end
        n_cmp++; if (vector !== 8'h43) begin n_fail++; $display("FAIL edge_vector_hold: got %h want 43", vector); end
        pulse_eoi(1'b0, 1'b0, 3'd0);
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL edge_eoi: got %h want 00", isr); end
    endtask

    task automatic test_simultaneous();
        irq_in = 8'h22;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        ack_cycle();
        n_cmp++; if (vector !== 8'h41) begin n_fail++; $display("FAIL simul_first: got %h want 41", vector); end
        tick(1);
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL simul_blocked: got %b want 0", int_out); end
        n_cmp++; if (isr !== 8'h02) begin n_fail++; $display("FAIL simul_isr: got %h want 02", isr); end
        pulse_eoi(1'b0, 1'b0, 3'd0);
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL simul_eoi: got %h want 00", isr); end
        tick(1);
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL simul_ir5_int: got %b want 1", int_out); end
        ack_cycle();
        n_cmp++; if (vector !== 8'h45) begin n_fail++; $display("FAIL simul_second: got %h want 45", vector); end
        pulse_eoi(1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_nesting();
        irq_in = 8'h04;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        ack_cycle();
        n_cmp++; if (isr !== 8'h04) begin n_fail++; $display("FAIL nest_isr2: got %h want 04", isr); end
        irq_in = 8'h10;
        tick(1);
        irq_in = 8'h00;
        tick(3);
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL nest_ir4_blocked: got %b want 0", int_out); end
        n_cmp++; if (irr !== 8'h10) begin n_fail++; $display("FAIL nest_ir4_pending: got %h want 10", irr); end
        irq_in = 8'h01;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL nest_ir0_int: got %b want 1", int_out); end
        ack_cycle();
        n_cmp++; if (vector !== 8'h40) begin n_fail++; $display("FAIL nest_ir0_vec: got %h want 40", vector); end
        n_cmp++; if (isr !== 8'h05) begin n_fail++; $display("FAIL nest_isr05: got %h want 05", isr); end
        pulse_eoi(1'b1, 1'b0, 3'd2);
        n_cmp++; if (isr !== 8'h01) begin n_fail++; $display("FAIL nest_spec_eoi: got %h want 01", isr); end
        pulse_eoi(1'b0, 1'b0, 3'd0);
        tick(1);
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL nest_ir4_int: got %b want 1", int_out); end
        ack_cycle();
        n_cmp++; if (vector !== 8'h44) begin n_fail++; $display("FAIL nest_ir4_vec: got %h want 44", vector); end
        // Rotating non-specific EOI on level 4 makes IR4 lowest priority.
        pulse_eoi(1'b0, 1'b1, 3'd0);
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL nest_rot_eoi: got %h want 00", isr); end
    endtask

    task automatic test_rotate();
        irq_in = 8'h48;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        ack_cycle();
        n_cmp++; if (vector !== 8'h46) begin n_fail++; $display("FAIL rot_ir6_first: got %h want 46", vector); end
        pulse_eoi(1'b0, 1'b0, 3'd0);
        tick(1);
        ack_cycle();
        n_cmp++; if (vector !== 8'h43) begin n_fail++; $display("FAIL rot_ir3_second: got %h want 43", vector); end
        pulse_eoi(1'b0, 1'b0, 3'd0);
        pulse_eoi(1'b1, 1'b1, 3'd7);
    endtask

    task automatic test_level_mode();
        ltim   = 1'b1;
        irq_in = 8'h80;
        tick(1);
        n_cmp++; if (irr !== 8'h80) begin n_fail++; $display("FAIL lvl_irr: got %h want 80", irr); end
        tick(1);
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL lvl_int: got %b want 1", int_out); end
        irq_in = 8'h00;
        tick(2);
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL lvl_drop_int: got %b want 0", int_out); end
        n_cmp++; if (irr !== 8'h00) begin n_fail++; $display("FAIL lvl_drop_irr: got %h want 00", irr); end
        // Request withdrawn as the first INTA arrives: spurious IR7.
        irq_in = 8'h40;
        tick(2);
        n_cmp++; if (int_out !== 1'b1) begin n_fail++; $display("FAIL spur_int: got %b want 1", int_out); end
        irq_in      = 8'h00;
        inta_strobe = 1'b1;
        tick(1);
        inta_strobe = 1'b0;
        tick(1);
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL spur_isr: got %h want 00", isr); end
        pulse_inta();
        n_cmp++; if (vector !== 8'h47) begin n_fail++; $display("FAIL spur_vector: got %h want 47", vector); end
        n_cmp++; if (vector_valid !== 1'b1) begin n_fail++; $display("FAIL spur_vvalid: got %b want 1", vector_valid); end
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL spur_isr_after: got %h want 00", isr); end
        ltim = 1'b0;
        tick(1);
    endtask

    task automatic test_aeoi();
`ifdef PIC_AEOI_EN
        aeoi   = 1'b1;
        irq_in = 8'h02;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        ack_cycle();
        n_cmp++; if (vector !== 8'h41) begin n_fail++; $display("FAIL aeoi_vector: got %h want 41", vector); end
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL aeoi_isr: got %h want 00", isr); end
        aeoi = 1'b0;
`endif
    endtask

    task automatic test_timeout();
        int cnt;
        irq_to = 8'h04;
        tick(1);
        irq_to = 8'h00;
        tick(1);
        n_cmp++; if (int_to !== 1'b1) begin n_fail++; $display("FAIL to_int: got %b want 1", int_to); end
        cnt = 0;
        while (int_to === 1'b1 && cnt < 50) begin
            tick(1);
            cnt++;
        end
        n_cmp++; if (cnt !== 10) begin n_fail++; $display("FAIL to_cycles: got %0d want 10", cnt); end
        n_cmp++; if (irr_to !== 8'h00) begin n_fail++; $display("FAIL to_irr: got %h want 00", irr_to); end
        n_cmp++; if (isr_to !== 8'h00) begin n_fail++; $display("FAIL to_isr: got %h want 00", isr_to); end
    endtask

    task automatic test_reset_mid();
        irq_in = 8'h08;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        pulse_inta();
        tick(1);
        n_cmp++; if (isr !== 8'h08) begin n_fail++; $display("FAIL mid_isr_set: got %h want 08", isr); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (isr !== 8'h00) begin n_fail++; $display("FAIL mid_rst_isr: got %h want 00", isr); end
        n_cmp++; if (vector !== 8'h00) begin n_fail++; $display("FAIL mid_rst_vector: got %h want 00", vector); end
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL mid_rst_int: got %b want 0", int_out); end
        tick(1);
        rst_n = 1'b1;
        tick(2);
        n_cmp++; if (int_out !== 1'b0) begin n_fail++; $display("FAIL mid_after_int: got %b want 0", int_out); end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_simultaneous();
        test_nesting();
        test_rotate();
        test_level_mode();
        test_aeoi();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
